// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU ops,
// FSM states, datapath mux selects and the control-word struct.
package mc_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_OR   = 4'b0111,
    ALU_AND  = 4'b1000,
    ALU_SUB  = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [1:0] {
    SRCA_RS1   = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_ZERO  = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } src_b_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MEM    = 2'd1,
    WB_PC     = 2'd2
  } wb_sel_e;

  // One control word per cycle; the top drives every output port from it.
  typedef struct packed {
    alu_op_e alu_op;
    src_a_e  src_a;
    src_b_e  src_b;
    logic    mem_req;
    logic    mem_we;
    logic    iord;
    logic    ir_we;
    logic    pc_we;
    logic    pc_sel;
    logic    aluout_we;
    logic    reg_we;
    wb_sel_e wb_sel;
    logic    illegal;
  } ctrl_t;

  function automatic logic opc_supported(input logic [6:0] opc);
    return (opc == OPC_R)      || (opc == OPC_I)   || (opc == OPC_LOAD) ||
           (opc == OPC_STORE)  || (opc == OPC_BRANCH) ||
           (opc == OPC_LUI)    || (opc == OPC_JAL);
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps (opcode, funct3, funct7[5]) onto the ALU op code for R/I-type
// arithmetic; the inverse of the ALU's own op table.
import mc_ctrl_pkg::*;

module alu_op_decoder (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      // Immediate forms have no subtract; bit 30 there is immediate data.
      3'b000: if (opcode == OPC_R && funct7_b5) alu_op = ALU_SUB;
              else                              alu_op = ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: if (funct7_b5) alu_op = ALU_SRA;
              else           alu_op = ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives ALU op, datapath mux selects and enables from state + instruction.
import mc_ctrl_pkg::*;

module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        zero_i,
  output logic [3:0]  alu_op_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        iord_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic        aluout_we_o,
  output logic        reg_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o
);

  state_e     state;
  ctrl_t      ctrl;
  alu_op_e    dec_op;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       br_ok;
  logic       is_load;
  logic       is_store;
  logic       unused_instr;

  assign opc      = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign br_ok    = (f3[2:1] == 2'b00);
  assign is_load  = (opc == OPC_LOAD);
  assign is_store = (opc == OPC_STORE);
  assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  alu_op_decoder u_dec (
    .opcode    (opc),
    .funct3    (f3),
    .funct7_b5 (instr_i[30]),
    .alu_op    (dec_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      case (state)
        ST_BOOT:   state <= ST_FETCH;
        ST_FETCH:  if (mem_ready_i) state <= ST_DECODE;
        ST_DECODE: state <= opc_supported(opc) ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          case (opc)
            OPC_R, OPC_I, OPC_LUI: state <= ST_WB;
            OPC_LOAD, OPC_STORE:   state <= ST_MEM;
            OPC_BRANCH:            state <= br_ok ? ST_FETCH : ST_TRAP;
            OPC_JAL:               state <= ST_FETCH;
            default:               state <= ST_TRAP;
          endcase
        end
        ST_MEM:    if (mem_ready_i) state <= is_store ? ST_FETCH : ST_WB;
        ST_WB:     state <= ST_FETCH;
        ST_TRAP:   state <= ST_TRAP;
        default:   state <= ST_BOOT;
      endcase
    end
  end

  // Moore decode; only FETCH/EXEC enables look at ready/zero this cycle.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.src_a   = SRCA_OLDPC;
        ctrl.src_b   = SRCB_FOUR;
        ctrl.alu_op  = ALU_ADD;
        ctrl.ir_we   = mem_ready_i;
        ctrl.pc_we   = mem_ready_i;
      end
      ST_DECODE: begin
        // Branch/JAL target precomputed into aluout here.
        ctrl.src_a     = SRCA_OLDPC;
        ctrl.src_b     = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.aluout_we = 1'b1;
      end
      ST_EXEC: begin
        case (opc)
          OPC_R: begin
            ctrl.alu_op    = dec_op;
            ctrl.aluout_we = 1'b1;
          end
          OPC_I: begin
            ctrl.src_b     = SRCB_IMM;
            ctrl.alu_op    = dec_op;
            ctrl.aluout_we = 1'b1;
          end
          OPC_LOAD, OPC_STORE: begin
            ctrl.src_b     = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
            ctrl.aluout_we = 1'b1;
          end
          OPC_BRANCH: begin
            if (br_ok) begin
              ctrl.alu_op = ALU_SUB;
              ctrl.pc_we  = f3[0] ? ~zero_i : zero_i;
              ctrl.pc_sel = 1'b1;
            end
          end
          OPC_LUI: begin
            ctrl.src_a     = SRCA_ZERO;
            ctrl.src_b     = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
            ctrl.aluout_we = 1'b1;
          end
          OPC_JAL: begin
            ctrl.reg_we = 1'b1;
            ctrl.wb_sel = WB_PC;
            ctrl.pc_we  = 1'b1;
            ctrl.pc_sel = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.mem_we  = is_store;
      end
      ST_WB: begin
        ctrl.reg_we = 1'b1;
        ctrl.wb_sel = is_load ? WB_MEM : WB_ALUOUT;
      end
      ST_TRAP: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

  assign alu_op_o    = ctrl.alu_op;
  assign alu_src_a_o = ctrl.src_a;
  assign alu_src_b_o = ctrl.src_b;
  assign mem_req_o   = ctrl.mem_req;
  assign mem_we_o    = ctrl.mem_we;
  assign iord_o      = ctrl.iord;
  assign ir_we_o     = ctrl.ir_we;
  assign pc_we_o     = ctrl.pc_we;
  assign pc_sel_o    = ctrl.pc_sel;
  assign aluout_we_o = ctrl.aluout_we;
  assign reg_we_o    = ctrl.reg_we;
  assign wb_sel_o    = ctrl.wb_sel;
  assign illegal_o   = ctrl.illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected cycle traces built from
// the instruction-class timing rules, compared cycle by cycle.
module tb_mc_ctrl_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_i;
  logic        mem_ready_i;
  logic        zero_i;
  logic [3:0]  alu_op_o;
  logic [1:0]  alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic        mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_sel_o;
  logic        aluout_we_o, reg_we_o, illegal_o;
  logic [1:0]  wb_sel_o;
  logic [18:0] obs;

  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_i     (instr_i),
    .mem_ready_i (mem_ready_i),
    .zero_i      (zero_i),
    .alu_op_o    (alu_op_o),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .iord_o      (iord_o),
    .ir_we_o     (ir_we_o),
    .pc_we_o     (pc_we_o),
    .pc_sel_o    (pc_sel_o),
    .aluout_we_o (aluout_we_o),
    .reg_we_o    (reg_we_o),
    .wb_sel_o    (wb_sel_o),
    .illegal_o   (illegal_o)
  );

  assign obs = {alu_op_o, alu_src_a_o, alu_src_b_o, mem_req_o, mem_we_o, iord_o,
                ir_we_o, pc_we_o, pc_sel_o, aluout_we_o, reg_we_o, wb_sel_o, illegal_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic logic [18:0] ev(int op, int a, int b, int req, int we, int iord,
                                     int irwe, int pcwe, int pcsel, int aluwe,
                                     int regwe, int wb, int ill);
    return {op[3:0], a[1:0], b[1:0], req[0], we[0], iord[0], irwe[0], pcwe[0],
            pcsel[0], aluwe[0], regwe[0], wb[1:0], ill[0]};
  endfunction

  // ALU op table: funct3 picks the op; bit30 turns add->sub (R only), srl->sra.
  function automatic int exp_op(input logic [31:0] ins);
    int tbl [8];
    int f3;
    tbl = '{0, 1, 2, 3, 4, 5, 7, 8};
    f3 = int'(ins[14:12]);
    if (f3 == 0 && ins[6:0] == OP_R && ins[30]) return 9;
    if (f3 == 5 && ins[30]) return 6;
    return tbl[f3];
  endfunction

  function automatic int rbit();
    return int'($urandom_range(0, 1));
  endfunction

  // Build the whole instruction's expected trace, then replay it.
  task automatic run_instr(input string nm, input logic [31:0] ins, input int fw,
                           input int mw, input int zf);
    logic [18:0] eq[$];
    int rq[$];
    int zq[$];
    int r, z, ld, st, f3;
    ld = (ins[6:0] == OP_LD) ? 1 : 0;
    st = (ins[6:0] == OP_ST) ? 1 : 0;
    f3 = int'(ins[14:12]);
    for (int i = 0; i <= fw; i++) begin
      r = (i == fw) ? 1 : 0;
      eq.push_back(ev(0, 1, 2, 1, 0, 0, r, r, 0, 0, 0, 0, 0));
      rq.push_back(r); zq.push_back(rbit());
    end
    eq.push_back(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    rq.push_back(rbit()); zq.push_back(rbit());
    z = (zf < 0) ? rbit() : zf;
    rq.push_back(rbit()); zq.push_back(z);
    case (ins[6:0])
      OP_R:         eq.push_back(ev(exp_op(ins), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      OP_I:         eq.push_back(ev(exp_op(ins), 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      OP_LD, OP_ST: eq.push_back(ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      OP_BR:        eq.push_back(ev(9, 0, 0, 0, 0, 0, 0, (f3 == 1) ? 1 - z : z, 1, 0, 0, 0, 0));
      OP_LUI:       eq.push_back(ev(0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      default:      eq.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0));
    endcase
    if (ld == 1 || st == 1) begin
      for (int i = 0; i <= mw; i++) begin
        r = (i == mw) ? 1 : 0;
        eq.push_back(ev(0, 0, 0, 1, st, 1, 0, 0, 0, 0, 0, 0, 0));
        rq.push_back(r); zq.push_back(rbit());
      end
    end
    if (ins[6:0] inside {OP_R, OP_I, OP_LUI, OP_LD}) begin
      eq.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ld, 0));
      rq.push_back(rbit()); zq.push_back(rbit());
    end
    for (int i = 0; i < eq.size(); i++) begin
      instr_i     = ins;
      mem_ready_i = (rq[i] != 0);
      zero_i      = (zq[i] != 0);
      @(negedge clk);
      checks++;
      if (obs !== eq[i]) begin
        errors++;
        $display("FAIL %s ins=%h cycle %0d: got %h expected %h", nm, ins, i, obs, eq[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Assumes rst_n low; leaves the DUT in FETCH at posedge+1.
  task automatic rel_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL boot_outputs: got %h expected 0", obs);
    end
    @(posedge clk); #1;
  endtask

  task automatic async_reset(input string nm);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL %s async_reset: got %h expected 0", nm, obs);
    end
    rel_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; instr_i = 32'h0000_0013; mem_ready_i = 1'b1; zero_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL reset_initial: got %h expected 0", obs);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", obs);
    end
    rel_reset();
  endtask

  task automatic test_alu();
    run_instr("add", 32'h002081B3, 0, 0, -1);
    run_instr("srai", 32'h4032D293, 0, 0, -1);
    run_instr("sub", 32'h403100B3, 0, 0, -1);
    run_instr("lui", 32'h12345237, 1, 0, -1);
    run_instr("addi_b30", 32'h40008093, 0, 0, -1);
  endtask

  task automatic test_load_store();
    run_instr("lw_stall", 32'h0080A203, 2, 2, -1);
    run_instr("sw", 32'h0020A423, 0, 0, -1);
    run_instr("sw_stall", 32'h0020A423, 1, 3, -1);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 32'h00208463, 0, 0, 1);
    run_instr("beq_not", 32'h00208463, 0, 0, 0);
    run_instr("bne_taken", 32'h00209463, 0, 0, 0);
    run_instr("bne_not", 32'h00209463, 0, 0, 1);
    run_instr("jal", 32'h008000EF, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      case ($urandom_range(0, 6))
        0: begin w[6:0] = OP_R; w[31:25] = rbit() != 0 ? 7'h20 : 7'h00; end
        1: w[6:0] = OP_I;
        2: w[6:0] = OP_LD;
        3: w[6:0] = OP_ST;
        4: begin w[6:0] = OP_BR; w[14:13] = 2'b00; end
        5: w[6:0] = OP_LUI;
        default: w[6:0] = OP_JAL;
      endcase
      run_instr("random", w, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
  endtask

  task automatic test_trap();
    instr_i = 32'h0000007F; mem_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL trap_fetch: got %h", obs);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      mem_ready_i = ($urandom_range(0, 1) != 0);
      zero_i      = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      checks++;
      if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
        errors++;
        $display("FAIL trap_sticky cycle %0d: got %h expected %h", i, obs,
                 ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      @(posedge clk); #1;
    end
    #2;
    async_reset("trap");
    // Unsupported branch funct3 traps after EXEC.
    instr_i = 32'h0020C463; mem_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL bad_branch_trap: got %h expected 00001", obs);
    end
    #2;
    async_reset("bad_branch");
  endtask

  task automatic test_reset_mid_mem();
    instr_i = 32'h0020A423; mem_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_we_o, iord_o} !== 3'b111) begin
      errors++;
      $display("FAIL store_mem_stall: got %b expected 111", {mem_req_o, mem_we_o, iord_o});
    end
    #2;
    async_reset("mid_store");
    run_instr("after_reset", 32'h002081B3, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_trap();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit that drives the existing 4-bit-op ALU and the surrounding datapath muxes/enables. It sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB with a ready handshake to a shared instruction/data memory. It is the producer side of the ALU `op` interface, and sits between the instruction register and the datapath of the multi-cycle core.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `instr_i`  in  32  instruction register contents (valid from DECODE onward).
- `mem_ready_i`  in  1  memory has completed the current request.
- `zero_i`  in  1  ALU result == 0 (used in branch EXEC).
- `alu_op_o`  out  4  ALU op: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 sra, 0111 or, 1000 and, 1001 sub.
- `alu_src_a_o`  out  2  0=rs1, 1=old_pc, 2=zero.
- `alu_src_b_o`  out  2  0=rs2, 1=imm, 2=const 4.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  store request (valid with `mem_req_o`).
- `iord_o`  out  1  0=address from PC, 1=address from aluout.
- `ir_we_o`  out  1  load IR and old_pc.
- `pc_we_o`  out  1  write PC.
- `pc_sel_o`  out  1  0=ALU result, 1=aluout register.
- `aluout_we_o`  out  1  capture ALU result.
- `reg_we_o`  out  1  register-file write.
- `wb_sel_o`  out  2  0=aluout, 1=mem data, 2=PC.
- `illegal_o`  out  1  sticky unsupported-opcode flag.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- BOOT: all outputs 0. Transition to FETCH after 1 cycle.
- FETCH: `mem_req_o=1`, `iord_o=0`. ALU computes PC+4 (`src_a=1`, `src_b=2`, add). Hold while `mem_ready_i=0`. When ready: `ir_we_o=1`, `pc_we_o=1`, `pc_sel_o=0`, then go to DECODE.
- DECODE: ALU computes old_pc+imm (add) and sets `aluout_we_o=1`. Opcode dispatch:
  - 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111 go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC, by opcode:
  - R-type: `src_a=0`, `src_b=0`, op from funct3/funct7, `aluout_we`, then WB.
  - I-ALU: same as R-type with `src_b=1`.
  - Load/store: rs1+imm add, `aluout_we`, then MEM.
  - Branch (funct3 000 beq / 001 bne): rs1−rs2 (op 1001). `pc_we_o = zero_i` (beq) or `!zero_i` (bne), `pc_sel_o=1`, then FETCH. Any other branch funct3 goes to TRAP.
  - LUI: `src_a=2`, `src_b=1`, add, `aluout_we`, then WB.
  - JAL: `reg_we_o=1`, `wb_sel_o=2`, `pc_we_o=1`, `pc_sel_o=1`, then FETCH.
- MEM: `mem_req_o=1`, `iord_o=1`, `mem_we_o=1` for store. Hold until `mem_ready_i`. Then: store goes to FETCH, load goes to WB.
- WB: `reg_we_o=1`. `wb_sel_o=1` for load, 0 otherwise. Then FETCH.
- TRAP: `illegal_o=1`, all other outputs 0. Exit only by reset.
- ALU op decode from funct3:
  - 000: sub only when R-type with funct7[5]=1, otherwise add.
  - 101: sra when funct7[5]=1 (R and I), otherwise srl.
  - Remaining funct3 values per the op table.
- Outputs not listed for a state are 0.

## Timing
- Outputs are Moore-style: combinational from state and `instr_i`, except FETCH/EXEC enables gated by `mem_ready_i`/`zero_i` in the same cycle.
- Minimum cycles per instruction, with zero memory wait:
  - Branch, JAL: 3.
  - ALU, LUI, store: 4.
  - Load: 5.
- Each cycle of `mem_ready_i=0` adds one cycle in FETCH or MEM. During the stall, `mem_req_o`, `mem_we_o` and `iord_o` are held stable.
- `mem_ready_i` outside FETCH/MEM is ignored.
- Reset assertion at any point: state becomes BOOT and all outputs become 0 immediately (asynchronous). This holds mid-memory-access, and TRAP is cleared.
- First `mem_req_o` comes 2 cycles after reset release (BOOT, then FETCH).

## Structure
- `mc_ctrl_pkg`: opcode constants, ALU op encodings, state enum, src_a/src_b/wb_sel encodings.
- Sub-module `alu_op_decoder`: combinational (opcode, funct3, funct7[5]) → `alu_op`. This is the direct inverse of the ALU's op table.
- Top: state register plus output decode.

## Test plan
- `add x3,x1,x2` (0x002081B3), ready always 1 → 4 cycles; EXEC `alu_op=0000`, `src_b=0`; WB `reg_we=1`, `wb_sel=0`.
- `srai x5,x5,3` (0x4032D293) → EXEC `alu_op=0110`, `src_b=1`. `sub x1,x2,x3` (0x403100B3) → `alu_op=1001`.
- `lw x4,8(x1)` (0x0080A203), `mem_ready_i` low 2 cycles in both FETCH and MEM → 9 cycles total; `iord_o=1`, `mem_we_o=0` held in MEM; WB `wb_sel=1`.
- `beq` (0x00208463) with `zero_i=1` → EXEC `pc_we=1`, `pc_sel=1`. With `zero_i=0` → `pc_we=0`. Both return to FETCH after 3 cycles.
- Opcode 0x0000007F in DECODE → TRAP next cycle, `illegal_o=1` sticky; `rst_n` low → all outputs 0 same cycle.
- `rst_n` asserted during MEM of a store → `mem_req_o`/`mem_we_o` drop to 0 asynchronously; BOOT, then FETCH on release.
